// File: rtl/cpu_pkg.sv
// Shared CPU-side types and widths for the data_out capture path.
`default_nettype none

package cpu_pkg;

   localparam int DATA_W    = 8;
   localparam int OVF_CNT_W = 16;

   typedef logic [DATA_W-1:0] byte_t;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/fifo_sync.sv
// Single-clock FIFO with occupancy count and full/empty flags; clr empties it synchronously.
`default_nettype none

module fifo_sync #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

   // Storage is not reset; dout is forced to zero while empty so stale entries never show.
   always_ff @(posedge clk) begin
      if (push && !clr) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

endmodule : fifo_sync

`default_nettype wire

// File: rtl/data_out_capture.sv
// Captures each change of the CPU data_out bus into a FIFO drained over valid/ready.
// Optional OUTCAP_OVF_CNT_EN adds a saturating 16-bit dropped-push counter port ovf_cnt.
`default_nettype none

module data_out_capture
   import cpu_pkg::*;
#(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    clr,
   input  logic [DATA_W-1:0]       data_in,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       out_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty,
   output logic                    overflow
`ifdef OUTCAP_OVF_CNT_EN
   ,
   output logic [OVF_CNT_W-1:0]    ovf_cnt
`endif
);

   logic [DATA_W-1:0] last_q;
   logic              last_vld_q;
   logic              overflow_q;
   logic              push_req;
   logic              pop;
   logic              fifo_push;
   logic              drop;

   assign push_req  = en & (!last_vld_q | (data_in != last_q));
   assign out_valid = !empty;
   assign pop       = out_valid & out_ready;
   // At full, a push is only accepted when the head leaves in the same cycle.
   assign fifo_push = push_req & (!full | pop);
   assign drop      = push_req & full & !pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
         overflow_q <= 1'b0;
      end else if (clr) begin
         last_q     <= '0;
         last_vld_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         if (en) begin
            last_q     <= data_in;
            last_vld_q <= 1'b1;
         end else begin
            last_vld_q <= 1'b0;
         end
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   assign overflow = overflow_q;

`ifdef OUTCAP_OVF_CNT_EN
   logic [OVF_CNT_W-1:0] ovf_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_cnt_q <= '0;
      end else if (clr) begin
         ovf_cnt_q <= '0;
      end else if (drop && (ovf_cnt_q != '1)) begin
         ovf_cnt_q <= ovf_cnt_q + 1'b1;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
`endif

   fifo_sync #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (fifo_push),
      .pop   (pop),
      .din   (data_in),
      .dout  (out_data),
      .count (count),
      .full  (full),
      .empty (empty)
   );

endmodule : data_out_capture

`default_nettype wire

// File: tb/tb_data_out_capture.sv
// Scoreboard bench for data_out_capture: stimulus queues expected values, a monitor checks pops.
`default_nettype none

module tb_data_out_capture;
   import cpu_pkg::*;

   localparam int DEPTH = 16;

   logic        clk;
   logic        rst;
   logic        en;
   logic        clr;
   byte_t       data_in;
   logic        out_valid;
   logic        out_ready;
   byte_t       out_data;
   logic [4:0]  count;
   logic        full;
   logic        empty;
   logic        overflow;
`ifdef OUTCAP_OVF_CNT_EN
   logic [15:0] ovf_cnt;
`endif

   int    n_vec  = 0;
   int    n_fail = 0;
   byte_t exp_q[$];

   data_out_capture #(
      .DATA_W (8),
      .DEPTH  (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .clr       (clr),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow)
`ifdef OUTCAP_OVF_CNT_EN
      ,
      .ovf_cnt   (ovf_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head must match the oldest outstanding expected value.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no output", out_data);
         end else begin
            byte_t e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL pop_data: got 0x%0h, expected 0x%0h", out_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input byte_t d, input logic expect_push);
      data_in = d;
      if (expect_push) exp_q.push_back(d);
      tick();
   endtask

   task automatic drain(input string name);
      int n = 0;
      out_ready = 1'b1;
      while (!empty && n < 200) begin
         tick();
         n++;
      end
      out_ready = 1'b0;
      check({name, "_empty"}, {31'd0, empty}, 32'd1);
      check({name, "_scoreboard_left"}, exp_q.size(), 32'd0);
   endtask

   task automatic do_clr();
      en  = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      exp_q.delete();
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; clr = 1'b0; data_in = 8'h5A; out_ready = 1'b0;

      // Reset held with an active, enabled bus
      repeat (3) tick();
      check("rst_count",     count,     32'd0);
      check("rst_empty",     empty,     32'd1);
      check("rst_full",      full,      32'd0);
      check("rst_out_valid", out_valid, 32'd0);
      check("rst_out_data",  out_data,  32'd0);
      check("rst_overflow",  overflow,  32'd0);
      rst = 1'b1;
      exp_q.push_back(8'h5A);
      tick();
      check("rst_first_valid", out_valid, 32'd1);
      check("rst_first_data",  out_data,  32'h5A);
      drain("rst_drain");

      // Change detect: 3,3,3,7,7,9 yields 3,7,9
      drive(8'h03, 1'b1); drive(8'h03, 1'b0); drive(8'h03, 1'b0);
      drive(8'h07, 1'b1); drive(8'h07, 1'b0); drive(8'h09, 1'b1);
      check("chg_count", count, 32'd3);
      // Disabled cycles must not push, even with a changing bus
      en = 1'b0;
      drive(8'h11, 1'b0); drive(8'h12, 1'b0);
      check("dis_count", count, 32'd3);
      drain("chg_drain");

      // Full / overflow: 17 distinct values, last one dropped
      do_clr();
      en = 1'b1;
      for (int i = 0; i < 17; i++) drive(byte_t'(8'h20 + i), i < 16);
      check("full_flag",     full,     32'd1);
      check("full_count",    count,    32'd16);
      check("full_overflow", overflow, 32'd1);
`ifdef OUTCAP_OVF_CNT_EN
      check("full_ovf_cnt",  ovf_cnt,  32'd1);
`endif
      drain("full_drain");
      check("ovf_sticky", overflow, 32'd1);
      do_clr();
      check("clr_overflow", overflow, 32'd0);

      // Simultaneous push and pop while full
      en = 1'b1;
      for (int i = 0; i < 16; i++) drive(byte_t'(8'h40 + i), 1'b1);
      check("sim_prefull", full, 32'd1);
      out_ready = 1'b1;
      drive(8'h50, 1'b1);
      out_ready = 1'b0;
      check("sim_count",    count,    32'd16);
      check("sim_overflow", overflow, 32'd0);
      drain("sim_drain");

      // Wrap: 40 values, each held two cycles, ready toggling
      for (int i = 0; i < 40; i++) begin
         out_ready = 1'b1;
         drive(byte_t'(8'h80 + i), 1'b1);
         out_ready = 1'b0;
         drive(byte_t'(8'h80 + i), 1'b0);
      end
      check("wrap_overflow", overflow, 32'd0);
      drain("wrap_drain");

      // Clear with count=5 and a same-cycle push
      for (int i = 0; i < 5; i++) drive(byte_t'(8'hC0 + i), 1'b1);
      check("clr_pre_count", count, 32'd5);
      clr = 1'b1;
      drive(8'hC5, 1'b0);
      clr = 1'b0;
      exp_q.delete();
      check("clr_count",     count,     32'd0);
      check("clr_empty",     empty,     32'd1);
      check("clr_out_valid", out_valid, 32'd0);
      check("clr_ovf",       overflow,  32'd0);
      drive(8'hC5, 1'b1);
      check("clr_repush_count", count,    32'd1);
      check("clr_repush_data",  out_data, 32'hC5);
      drain("clr_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule : tb_data_out_capture

`default_nettype wire
